// File: rtl/iq_readout_seq_if.sv
// Bundle of the sequencer's host control, buffer read-side and word-stream signals.
// master = the sequencer; slave = the host, the IQ buffer and the word sink.
interface iq_readout_seq_if #(
    parameter int CNT_W = 14
);
    // Host control
    logic             start;
    logic [CNT_W-1:0] count;
    logic             abort;
    logic             busy;
    logic             done;

    // IQ buffer read side
    logic             buf_rd_sync;
    logic             buf_rd_i;
    logic             buf_rd_q;
    logic [15:0]      buf_rd_iq;

    // Word stream. A word transfers on a rd_clk edge where out_valid && out_ready.
    // Once raised, out_valid stays high and out_data stays stable until that
    // transfer (an abort is the only exception), and out_ready may depend
    // combinationally on nothing from this block.
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  start, count, abort, buf_rd_iq, out_ready,
        output busy, done, buf_rd_sync, buf_rd_i, buf_rd_q, out_data, out_valid
    );

    modport slave (
        output start, count, abort, buf_rd_iq, out_ready,
        input  busy, done, buf_rd_sync, buf_rd_i, buf_rd_q, out_data, out_valid
    );
endinterface

// File: rtl/iq_readout_seq.sv
// Read-side sequencer: re-syncs the IQ buffer pointer, then streams COUNT I/Q pairs as 16-bit words.
// Optional trailing checksum word when IQ_RDSEQ_CKSUM_EN is defined.
module iq_readout_seq #(
    parameter int CNT_W = 14
) (
    input  logic       rd_clk,
    input  logic       rd_rst_n,
    iq_readout_seq_if.master bus,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SYNC   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_XFER   = 3'd3;
`ifdef IQ_RDSEQ_CKSUM_EN
    localparam logic [2:0] S_CKSUM  = 3'd4;
`endif
    localparam logic [2:0] S_DRAIN  = 3'd5;

    logic [2:0]       state;
    logic             phase_q;      // 0: next capture is the I word, 1: the Q word
    logic [CNT_W-1:0] pair_cnt;
    logic [CNT_W-1:0] cnt_lat;
    logic [15:0]      out_data_r;
    logic             out_valid_r;
    logic             done_r;
`ifdef IQ_RDSEQ_CKSUM_EN
    logic [15:0]      cksum;
`endif

    logic             capture_ok;
    logic             xfer_cap;
    logic             last_pair;

    // Abort wins over capture, so the buffer address is never advanced on an abort cycle.
    assign capture_ok = (!out_valid_r || bus.out_ready) && !bus.abort;
    assign xfer_cap   = (state == S_XFER) && capture_ok;
    assign last_pair  = (pair_cnt + CNT_W'(1)) == cnt_lat;

    assign bus.buf_rd_sync = (state == S_SYNC) && !bus.abort;
    assign bus.buf_rd_i    = xfer_cap && !phase_q;
    assign bus.buf_rd_q    = xfer_cap && phase_q;

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign dbg_state     = state;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state       <= S_IDLE;
            phase_q     <= 1'b0;
            pair_cnt    <= '0;
            cnt_lat     <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
`ifdef IQ_RDSEQ_CKSUM_EN
            cksum       <= '0;
`endif
        end else begin
            done_r <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        cnt_lat  <= bus.count;
                        pair_cnt <= '0;
                        phase_q  <= 1'b0;
`ifdef IQ_RDSEQ_CKSUM_EN
                        cksum    <= '0;
`endif
                        state    <= S_SYNC;
                    end else begin
                        done_r <= 1'b1;
                    end
                end
            end else if (bus.abort) begin
                // The pending word is dropped; the sink never sees it.
                state       <= S_IDLE;
                out_valid_r <= 1'b0;
                phase_q     <= 1'b0;
                done_r      <= 1'b1;
            end else begin
                case (state)
                    S_SYNC:   state <= S_SETTLE;
                    S_SETTLE: state <= S_XFER;
                    S_XFER: begin
                        if (capture_ok) begin
                            out_data_r  <= bus.buf_rd_iq;
                            out_valid_r <= 1'b1;
`ifdef IQ_RDSEQ_CKSUM_EN
                            cksum       <= cksum + bus.buf_rd_iq;
`endif
                            if (phase_q) begin
                                phase_q  <= 1'b0;
                                pair_cnt <= pair_cnt + CNT_W'(1);
                                if (last_pair) begin
`ifdef IQ_RDSEQ_CKSUM_EN
                                    state <= S_CKSUM;
`else
                                    state <= S_DRAIN;
`endif
                                end
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end
                    end
`ifdef IQ_RDSEQ_CKSUM_EN
                    S_CKSUM: begin
                        if (capture_ok) begin
                            out_data_r  <= cksum;
                            out_valid_r <= 1'b1;
                            state       <= S_DRAIN;
                        end
                    end
`endif
                    S_DRAIN: begin
                        if (!out_valid_r || bus.out_ready) begin
                            out_valid_r <= 1'b0;
                            done_r      <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iq_readout_seq.sv
// Self-checking bench for iq_readout_seq with a behavioural IQ buffer model and a word scoreboard.
module tb_iq_readout_seq;

`ifdef IQ_RDSEQ_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic       rd_clk = 1'b0;
    logic       rd_rst_n;
    logic [2:0] dbg_state;

    always #5 rd_clk = ~rd_clk;

    iq_readout_seq_if #(.CNT_W(14)) bus ();

    iq_readout_seq #(.CNT_W(14)) dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Buffer model: registered read from the next address, I/Q mux after the register.
    logic [15:0] mem_i [16];
    logic [15:0] mem_q [16];
    logic [12:0] addr = '0;
    logic [12:0] addr_n;
    logic [15:0] dout_i = '0;
    logic [15:0] dout_q = '0;

    always_comb begin
        addr_n = addr;
        if (bus.buf_rd_sync)   addr_n = '0;
        else if (bus.buf_rd_q) addr_n = addr + 13'd1;
    end

    always @(posedge rd_clk) begin
        addr   <= addr_n;
        dout_i <= mem_i[addr_n[3:0]];
        dout_q <= mem_q[addr_n[3:0]];
    end

    assign bus.buf_rd_iq = bus.buf_rd_i ? dout_i : dout_q;

    logic [15:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    int r_acc, r_rdq, r_sync, r_done, first_valid, last_acc, done_it, sync_it;

    function automatic int words(input int c);
        return 2 * c + ((CK_EN && c != 0) ? 1 : 0);
    endfunction

    task automatic load_default_mem();
        for (int n = 0; n < 16; n++) begin
            mem_i[n] = 16'h1000 + 16'(n);
            mem_q[n] = 16'h2000 + 16'(n);
        end
    endtask

    task automatic push_expected(input int c);
        logic [15:0] sum;
        sum = '0;
        for (int n = 0; n < c; n++) begin
            exp_q.push_back(mem_i[n % 16]);
            exp_q.push_back(mem_q[n % 16]);
            sum = sum + mem_i[n % 16] + mem_q[n % 16];
        end
        if (CK_EN && c != 0) exp_q.push_back(sum);
    endtask

    task automatic do_start(input int c);
        @(negedge rd_clk);
        bus.start = 1'b1;
        bus.count = 14'(c);
        push_expected(c);
    endtask

    // Runs cycles until done is seen or stop_after words were accepted; scoreboards every accepted word.
    task automatic sb_run(input int max_cyc, input int ready_mode, input int stop_after, input int start_at);
        logic        prev_stall;
        logic [15:0] prev_data;
        logic [15:0] exp_w;
        bit          finished;
        prev_stall = 1'b0;
        prev_data  = '0;
        finished   = 1'b0;
        r_acc = 0; r_rdq = 0; r_sync = 0; r_done = 0;
        first_valid = 0; last_acc = 0; done_it = 0; sync_it = 0;
        for (int it = 1; it <= max_cyc && !finished; it++) begin
            @(negedge rd_clk);
            bus.start = (it == start_at);
            if (it == start_at) bus.count = 14'd5;
            bus.out_ready = (ready_mode == 0) ? 1'b1 : ((it % 4) == 1 || (it % 4) == 0);
            #1;
            checks++;
            if (bus.buf_rd_i && bus.buf_rd_q) begin
                failures++;
                $display("FAIL strobe_both it=%0d rd_i=%b rd_q=%b required not both 1", it, bus.buf_rd_i, bus.buf_rd_q);
            end
            if (bus.out_valid && !bus.out_ready) begin
                checks++;
                if (bus.buf_rd_i || bus.buf_rd_q) begin
                    failures++;
                    $display("FAIL strobe_in_stall it=%0d rd_i=%b rd_q=%b required 0/0", it, bus.buf_rd_i, bus.buf_rd_q);
                end
            end
            if (prev_stall) begin
                checks++;
                if (bus.out_data !== prev_data) begin
                    failures++;
                    $display("FAIL data_hold it=%0d got=%h required=%h", it, bus.out_data, prev_data);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.buf_rd_q) r_rdq++;
            if (bus.buf_rd_sync) begin r_sync++; sync_it = it; end
            if (bus.out_valid && first_valid == 0) first_valid = it;
            if (bus.done) begin r_done++; done_it = it; finished = 1'b1; end
            if (bus.out_valid && bus.out_ready) begin
                r_acc++;
                last_acc = it;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_word it=%0d got=%h required=no word", it, bus.out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (bus.out_data !== exp_w) begin
                        failures++;
                        $display("FAIL word it=%0d got=%h required=%h", it, bus.out_data, exp_w);
                    end
                end
                if (r_acc == stop_after) finished = 1'b1;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL timeout got=no done after %0d cycles required=done", max_cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.buf_rd_sync !== 1'b0 ||
            bus.buf_rd_i !== 1'b0 || bus.buf_rd_q !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.out_data !== 16'h0 || dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL %s got busy=%b done=%b sync=%b i=%b q=%b valid=%b data=%h st=%0d required all 0",
                     tag, bus.busy, bus.done, bus.buf_rd_sync, bus.buf_rd_i, bus.buf_rd_q,
                     bus.out_valid, bus.out_data, dbg_state);
        end
    endtask

    task automatic test_reset();
        rd_rst_n      = 1'b0;
        bus.start     = 1'b0;
        bus.count     = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        load_default_mem();
        repeat (3) @(negedge rd_clk);
        #1;
        check_idle_outputs("reset_values");
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        @(negedge rd_clk);
        #1;
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_basic();
        do_start(4);
        sb_run(100, 0, -1, 0);
        checks++;
        if (r_sync != 1 || sync_it != 1) begin
            failures++;
            $display("FAIL sync_pulse got count=%0d at=%0d required count=1 at=1", r_sync, sync_it);
        end
        checks++;
        if (first_valid != 4) begin
            failures++;
            $display("FAIL first_valid got=%0d required=4", first_valid);
        end
        checks++;
        if (r_acc != words(4) || last_acc - first_valid != words(4) - 1) begin
            failures++;
            $display("FAIL basic_words got=%0d span=%0d required=%0d consecutive", r_acc, last_acc - first_valid, words(4));
        end
        checks++;
        if (r_rdq != 4) begin
            failures++;
            $display("FAIL basic_rdq got=%0d required=4", r_rdq);
        end
        checks++;
        if (done_it != last_acc + 1 || r_done != 1) begin
            failures++;
            $display("FAIL basic_done got at=%0d required at=%0d", done_it, last_acc + 1);
        end
        @(negedge rd_clk);
        #1;
        check_idle_outputs_nodata("basic_after_done");
    endtask

    task automatic check_idle_outputs_nodata(input string tag);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s got busy=%b done=%b valid=%b left=%0d required 0/0/0/0",
                     tag, bus.busy, bus.done, bus.out_valid, exp_q.size());
        end
    endtask

    task automatic test_stall();
        do_start(4);
        sb_run(200, 1, -1, 0);
        checks++;
        if (r_acc != words(4) || r_rdq != 4 || r_done != 1) begin
            failures++;
            $display("FAIL stall_counts got words=%0d rdq=%0d done=%0d required %0d/4/1", r_acc, r_rdq, r_done, words(4));
        end
        @(negedge rd_clk);
        bus.out_ready = 1'b1;
        #1;
        check_idle_outputs_nodata("stall_after_done");
    endtask

    task automatic test_count_zero();
        @(negedge rd_clk);
        bus.start = 1'b1;
        bus.count = '0;
        for (int it = 1; it <= 4; it++) begin
            @(negedge rd_clk);
            bus.start = 1'b0;
            #1;
            checks++;
            if (bus.busy || bus.out_valid || bus.buf_rd_sync || bus.buf_rd_i || bus.buf_rd_q ||
                bus.done !== (it == 1)) begin
                failures++;
                $display("FAIL count_zero it=%0d got busy=%b valid=%b sync=%b i=%b q=%b done=%b required done=%0d only",
                         it, bus.busy, bus.out_valid, bus.buf_rd_sync, bus.buf_rd_i, bus.buf_rd_q, bus.done, it == 1);
            end
        end
    endtask

    task automatic test_abort();
        do_start(8);
        sb_run(100, 0, 3, 0);
        checks++;
        if (r_acc != 3) begin
            failures++;
            $display("FAIL abort_pre got=%0d required=3", r_acc);
        end
        @(negedge rd_clk);
        bus.abort = 1'b1;
        #1;
        checks++;
        if (bus.buf_rd_i || bus.buf_rd_q) begin
            failures++;
            $display("FAIL abort_strobe got i=%b q=%b required 0/0", bus.buf_rd_i, bus.buf_rd_q);
        end
        @(negedge rd_clk);
        bus.abort = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1 || dbg_state !== 3'd0) begin
            failures++;
            $display("FAIL abort_next got valid=%b busy=%b done=%b st=%0d required 0/0/1/0",
                     bus.out_valid, bus.busy, bus.done, dbg_state);
        end
        @(negedge rd_clk);
        #1;
        checks++;
        if (bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_done_width got=%b required=0", bus.done);
        end
        exp_q.delete();
        do_start(1);
        sb_run(100, 0, -1, 0);
        checks++;
        if (r_acc != words(1) || r_done != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_abort got words=%0d done=%0d left=%0d required %0d/1/0", r_acc, r_done, exp_q.size(), words(1));
        end
    endtask

    task automatic test_start_busy();
        do_start(8);
        sb_run(300, 0, -1, 6);
        checks++;
        if (r_acc != words(8) || r_done != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL start_busy got words=%0d done=%0d left=%0d required %0d/1/0", r_acc, r_done, exp_q.size(), words(8));
        end
        for (int it = 0; it < 20; it++) begin
            @(negedge rd_clk);
            #1;
            checks++;
            if (bus.busy || bus.done || bus.out_valid) begin
                failures++;
                $display("FAIL start_busy_tail it=%0d got busy=%b done=%b valid=%b required 0/0/0", it, bus.busy, bus.done, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_start(8);
        sb_run(100, 0, 4, 0);
        @(negedge rd_clk);
        #2;
        rd_rst_n = 1'b0;
        #1;
        check_idle_outputs("async_reset_mid");
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        exp_q.delete();
        do_start(2);
        sb_run(100, 0, -1, 0);
        checks++;
        if (r_acc != words(2) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_reset_run got words=%0d left=%0d required %0d/0", r_acc, exp_q.size(), words(2));
        end
    endtask

`ifdef IQ_RDSEQ_CKSUM_EN
    task automatic test_cksum();
        mem_i[0] = 16'hFFFF;
        mem_q[0] = 16'h0001;
        mem_i[1] = 16'h0002;
        mem_q[1] = 16'h0003;
        do_start(2);
        sb_run(100, 1, -1, 0);
        checks++;
        if (r_acc != 5 || r_rdq != 2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL cksum_counts got words=%0d rdq=%0d left=%0d required 5/2/0", r_acc, r_rdq, exp_q.size());
        end
        load_default_mem();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog got=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_count_zero();
        test_abort();
        test_start_busy();
`ifdef IQ_RDSEQ_CKSUM_EN
        test_cksum();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iq_readout_seq.md
Name: iq_readout_seq

Overview:
- Read-side sequencer for the 8K x 32b IQ sample buffer. It runs in the rd_clk domain.
- On a host start command it re-aligns the buffer read pointer with a one-cycle rd_sync pulse. It then drives rd_i and rd_q to stream COUNT IQ pairs as 16-bit words, in the order I0,Q0,I1,Q1,..., to a downstream valid/ready word sink such as the SPI/host transfer FIFO.
- It replaces ad-hoc rd_i/rd_q strobing in the host-transfer logic.

Parameters:
- CNT_W, 14, width of the pair-count input; it must be able to hold 8192.

Ports:
- rd_clk  in  1  clock, shared with the buffer read side.
- rd_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse requesting a readout; sampled only in IDLE.
- count  in  CNT_W  number of IQ pairs to read; sampled together with start.
- abort  in  1  terminate the current readout.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a readout.
- buf_rd_sync  out  1  to the buffer's rd_sync input.
- buf_rd_i  out  1  to rd_i; selects the I half of the buffer output.
- buf_rd_q  out  1  to rd_q; advances the buffer read address.
- buf_rd_iq  in  16  from the buffer's rd_iq output.
- out_data  out  16  word to the sink.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word; a transfer happens when out_valid && out_ready.

Behaviour:
- Reset (asynchronous, rd_rst_n=0) puts the block in IDLE:
  - busy=0, done=0, buf_rd_sync=0, buf_rd_i=0, buf_rd_q=0, out_valid=0, out_data=0.
  - Pair counter = 0, phase = I, checksum = 0.
- Buffer contract:
  - Read data is registered with 1-cycle latency from the buffer's read address.
  - buf_rd_i is a combinational mux select at the data output.
  - buf_rd_q=1 advances the address so the next pair's data is present in the following cycle.
  - Holding buf_rd_q=0 holds the current data, so stalls need no skid storage.
- States: IDLE -> SYNC -> SETTLE -> XFER -> DRAIN -> IDLE.
- IDLE:
  - start=1 with count!=0: latch count, go to SYNC.
  - start=1 with count=0: done=1 on the next cycle, stay in IDLE, no buffer strobes.
- SYNC: buf_rd_sync=1 for exactly one cycle, then SETTLE.
- SETTLE: one cycle with all buf_* strobes at 0 while the read pointer propagates, then XFER.
- XFER:
  - Capture is allowed when !out_valid || out_ready.
  - Phase I, capture allowed: buf_rd_i=1, buf_rd_q=0; out_data<=buf_rd_iq, out_valid<=1; phase<=Q.
  - Phase Q, capture allowed: buf_rd_i=0, buf_rd_q=1; out_data<=buf_rd_iq, out_valid<=1; phase<=I; pair counter +1.
  - Capture not allowed: buf_rd_i=0, buf_rd_q=0, and all state is held.
  - buf_rd_i and buf_rd_q are never both 1.
  - buf_rd_q is asserted only on the cycle the Q word is captured.
  - After capturing the Q word of the last pair (pair counter == latched count), go to DRAIN.
- Throughput: one word per cycle when out_ready is held high; first out_valid appears 3 cycles after start.
- DRAIN: wait until the last word is accepted (out_valid=0 or out_valid&&out_ready), then done=1 for one cycle and return to IDLE.
- out_valid deasserts on acceptance when no new capture happens in the same cycle.
- out_data is stable while out_valid && !out_ready.
- Boundary and priority rules:
  - start while busy: ignored.
  - abort in any non-IDLE state: go to IDLE on the next edge; out_valid<=0, the pending word is discarded, strobes drop to 0, done=1 for one cycle.
  - abort in IDLE: no effect.
  - abort has priority over capture in the same cycle.
  - start and abort together in IDLE: start is honoured.
  - count=8192 is legal: the buffer read address wraps naturally; the sequencer does no address arithmetic.
- Pair counter width is CNT_W. count values above 8192 are legal; the address wraps and data repeats.

Optional Feature:
- Macro IQ_RDSEQ_CKSUM_EN.
- When defined:
  - A 16-bit checksum accumulates the modulo-2^16 sum of every captured word.
  - The checksum clears on each start acceptance.
  - After the last Q word the block enters state CKSUM, which presents the checksum as one extra word using the same valid/ready rule with no buffer strobes, then goes to DRAIN.
  - Total words out = 2*count+1. count=0 yields no words.
- When undefined: no CKSUM state, no checksum logic; total words = 2*count.

Test Plan:
- Start, count=4, out_ready=1, buffer holds I=0x1000+n, Q=0x2000+n from the sync point -> buf_rd_sync high one cycle; 8 words 0x1000,0x2000,...,0x1003,0x2003 on consecutive cycles; exactly 4 buf_rd_q pulses; done pulses one cycle after the last accept.
- Same as above with out_ready toggled 1,0,0,1 repeating -> identical word sequence; out_data stable during stalls; buf_rd_i/buf_rd_q low in every stalled cycle.
- count=0 -> no buf strobes, no out_valid, done pulse one cycle after start, busy stays 0.
- count=8 with abort asserted after the 3rd accepted word -> next cycle: out_valid=0, busy=0, single done pulse; a new start count=1 then produces 2 words correctly.
- start pulsed again during a count=8 readout -> ignored; exactly 16 words, one done.
- With IQ_RDSEQ_CKSUM_EN defined, count=2, words 0xFFFF,0x0001,0x0002,0x0003 -> 5th word = 0x0005; a reset mid-transfer returns all outputs to reset values asynchronously.
